// File: rtl/c_split_1ton_pkg.sv
`default_nettype none
// ============================================================================
// Module      : c_split_1ton_pkg
// Description : Shared state encodings and log2 helper for the 1-to-N splitter.
// Revision    : 1.0 - initial release
// ============================================================================
package c_split_1ton_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPLIT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Ceiling log2; clogb(1) == 0, so a single-port splitter adds no carry bits.
  function automatic int clogb(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/c_split_1ton.sv
`default_nettype none
// ============================================================================
// Module      : c_split_1ton
// Description : Greedy sequential splitter of one wide total into num_ports
//               saturating addends, one slot per cycle, with output hold.
// Revision    : 1.0 - initial release
// ============================================================================
module c_split_1ton
  import c_split_1ton_pkg::*;
#(
  parameter int num_ports = 4,
  parameter int width     = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [clogb(num_ports)+width-1:0]    data_in,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [num_ports*width-1:0]           data_out,
  output logic                                 overflow
);

  localparam int c_in_w  = clogb(num_ports) + width;
  localparam int c_idx_w = (clogb(num_ports) > 1) ? clogb(num_ports) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(num_ports - 1);
  localparam logic [c_in_w-1:0]  c_max_chunk = c_in_w'((64'd1 << width) - 64'd1);

  state_e                   state_q, state_d;
  logic [c_in_w-1:0]        rem_q, rem_d;
  logic [c_idx_w-1:0]       idx_q, idx_d;
  logic [num_ports*width-1:0] data_q, data_d;
  logic                     ovf_q, ovf_d;

  logic                     w_sat;
  logic [c_in_w-1:0]        w_chunk;
  logic [width-1:0]         w_chunk_lo;
  logic [c_in_w-1:0]        w_rem_rest;

  // Single comparator drives both the full-width subtrahend and the slot value.
  assign w_sat      = (rem_q > c_max_chunk);
  assign w_chunk    = w_sat ? c_max_chunk : rem_q;
  assign w_chunk_lo = w_sat ? {width{1'b1}} : rem_q[width-1:0];
  assign w_rem_rest = rem_q - w_chunk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          rem_d   = data_in;
          idx_d   = '0;
          data_d  = '0;
          ovf_d   = 1'b0;
          state_d = ST_SPLIT;
        end
      end
      ST_SPLIT: begin
        data_d[int'(idx_q)*width +: width] = w_chunk_lo;
        rem_d = w_rem_rest;
        if (idx_q == c_last_idx) begin
          // Any residue left after the last slot is dropped and flagged.
          ovf_d   = (w_rem_rest != '0);
          idx_d   = '0;
          state_d = ST_HOLD;
        end else begin
          idx_d = idx_q + c_idx_w'(1);
        end
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);
  assign data_out  = data_q;
  assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_c_split_1ton.sv
`default_nettype none
// ============================================================================
// Module      : tb_c_split_1ton
// Description : Scoreboard bench for c_split_1ton (4x8 main instance, 1x4 aux).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_c_split_1ton;

  localparam int NP   = 4;
  localparam int W    = 8;
  localparam int IW   = 10;
  localparam int MAXV = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] data_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [NP*W-1:0] data_out;
  logic          overflow;

  logic          b_in_valid = 1'b0;
  logic          b_in_ready;
  logic [3:0]    b_data_in = '0;
  logic          b_out_valid;
  logic          b_out_ready = 1'b1;
  logic [3:0]    b_data_out;
  logic          b_overflow;

  always #5 clk = ~clk;

  c_split_1ton #(.num_ports(NP), .width(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .overflow(overflow)
  );

  c_split_1ton #(.num_ports(1), .width(4)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .data_in(b_data_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .data_out(b_data_out), .overflow(b_overflow)
  );

  typedef struct {
    logic [NP*W-1:0] slots;
    logic            ovf;
    int              total;
    int              acc;
  } exp_t;

  exp_t            q[$];
  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  logic            ov_prev = 1'b0;
  logic [NP*W-1:0] held = '0;
  logic            held_ovf = 1'b0;

  task automatic chk(input bit ok, input string name,
                     input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Greedy fill as a closed form: slot i holds whatever of the total lies in
  // the band [i*MAXV, (i+1)*MAXV).
  function automatic exp_t model(input int total, input int acc);
    exp_t e;
    int   v;
    e.total = total;
    e.acc   = acc;
    e.ovf   = (total > NP * MAXV);
    e.slots = '0;
    for (int i = 0; i < NP; i++) begin
      v = total - i * MAXV;
      if (v < 0)    v = 0;
      if (v > MAXV) v = MAXV;
      e.slots[i*W +: W] = W'(v);
    end
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    exp_t e;
    int   sum;
    if (reset) begin
      ov_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) q.push_back(model(int'(data_in), cyc));
      if (out_valid) begin
        chk(!in_ready, "in_ready_in_hold", 64'(in_ready), 0);
        if (!ov_prev) begin
          if (q.size() == 0) begin
            chk(1'b0, "unexpected_out_valid", 1, 0);
          end else begin
            e = q.pop_front();
            chk(data_out == e.slots, "slots", 64'(data_out), 64'(e.slots));
            chk(overflow == e.ovf, "overflow", 64'(overflow), 64'(e.ovf));
            chk((cyc - e.acc) == NP + 1, "latency", 64'(cyc - e.acc), NP + 1);
            if (!e.ovf) begin
              sum = 0;
              for (int i = 0; i < NP; i++) sum += int'(data_out[i*W +: W]);
              chk(sum == e.total, "resum", 64'(sum), 64'(e.total));
            end
            held     = data_out;
            held_ovf = overflow;
          end
        end else begin
          chk(data_out == held && overflow == held_ovf, "hold_stable",
              64'(data_out), 64'(held));
        end
      end
      ov_prev = out_valid && !out_ready;
    end
  end

  task automatic send(input int total);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(in_ready, "send_wait", 64'(in_ready), 1);
    in_valid = 1'b1;
    data_in  = IW'(total);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(in_ready && !out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(in_ready && !out_valid, "wait_idle", 64'(in_ready), 1);
  endtask

  task automatic wait_ov();
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(out_valid, "wait_out_valid", 64'(out_valid), 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int directed[4];
    int sent;
    int n;
    int bt[2];
    directed = '{0, 300, 1020, 1023};
    bt       = '{9, 15};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk(in_ready == 1'b1, "rst_in_ready", 64'(in_ready), 1);
    chk(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 0);
    chk(overflow == 1'b0, "rst_overflow", 64'(overflow), 0);
    chk(data_out == '0, "rst_data_out", 64'(data_out), 0);
    chk(b_in_ready && !b_out_valid, "rst_b", 64'(b_in_ready), 1);
    reset = 1'b0;

    foreach (directed[i]) begin
      send(directed[i]);
      wait_idle();
    end

    out_ready = 1'b0;
    send(500);
    wait_ov();
    repeat (10) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      data_in  = IW'(77);
      chk(out_valid && !in_ready, "bp_hold", 64'(out_valid), 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk(in_ready && !out_valid, "bp_release", 64'(in_ready), 1);

    send(900);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk(in_ready == 1'b1, "mid_rst_in_ready", 64'(in_ready), 1);
    chk(out_valid == 1'b0, "mid_rst_out_valid", 64'(out_valid), 0);
    chk(overflow == 1'b0, "mid_rst_overflow", 64'(overflow), 0);
    chk(data_out == '0, "mid_rst_data_out", 64'(data_out), 0);
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    send(7);
    wait_idle();

    sent = 0;
    for (int c = 0; c < 20000 && sent < 1000; c++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid) begin
        in_valid = 1'b0;
        sent++;
      end else if (in_ready && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b1;
        data_in  = IW'($urandom_range(0, NP * MAXV));
      end
    end
    in_valid  = 1'b0;
    chk(sent == 1000, "random_sent", 64'(sent), 1000);
    out_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(q.size() == 0, "drain", 64'(q.size()), 0);

    foreach (bt[i]) begin
      b_in_valid = 1'b1;
      b_data_in  = 4'(bt[i]);
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      chk(!b_out_valid && !b_in_ready, "b_split", 64'(b_out_valid), 0);
      @(posedge clk); #1;
      chk(b_out_valid, "b_out_valid", 64'(b_out_valid), 1);
      chk(b_data_out == 4'(bt[i]), "b_slot", 64'(b_data_out), 64'(bt[i]));
      chk(!b_overflow, "b_overflow", 64'(b_overflow), 0);
      @(posedge clk); #1;
      chk(b_in_ready && !b_out_valid, "b_idle", 64'(b_in_ready), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
